// File: rtl/alu_result_fifo.sv
// alu_result_fifo: in-order ready/valid buffer for ALU results (Y plus overflow/err flags).
// Optional feature macro: ALU_RESULT_FIFO_STATS_EN adds saturating overflow/error counters.
// o_READY and o_VALID are derived from registered occupancy only, so there is no
// combinational path between the two handshakes.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_FLUSH,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_Y,
  input  logic             i_overflow,
  input  logic             i_err,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_overflow,
  output logic             o_err,
  output logic [CW-1:0]    o_count,
  output logic [7:0]       o_ovf_cnt,
  output logic [7:0]       o_err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign o_READY = (count != CW'(DEPTH));
  assign o_VALID = (count != '0);
  assign push    = i_VALID & o_READY;
  assign pop     = o_VALID & i_READY;
  assign o_count = count;

  assign {o_err, o_overflow, o_Y} = mem[rd_ptr];

  // Entry storage; contents are not reset, only the pointers define validity.
  always_ff @(posedge i_CLK) begin
    if (push && !i_RST && !i_FLUSH) begin
      mem[wr_ptr] <= {i_err, i_overflow, i_Y};
    end
  end

  // Pointers and occupancy: reset over flush over handshakes.
  always_ff @(posedge i_CLK) begin
    if (i_RST || i_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [7:0] ovf_cnt;
  logic [7:0] err_cnt;

  // Saturating result statistics; flush keeps them, only reset clears them.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else if (!i_FLUSH && push) begin
      if (i_overflow && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 8'd1;
      if (i_err && err_cnt != '1)      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_ovf_cnt = ovf_cnt;
  assign o_err_cnt = err_cnt;
`else
  assign o_ovf_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             i_CLK = 1'b0;
  logic             i_RST = 1'b1;
  logic             i_FLUSH = 1'b0;
  logic             i_VALID = 1'b0;
  logic             o_READY;
  logic [WIDTH-1:0] i_Y = '0;
  logic             i_overflow = 1'b0;
  logic             i_err = 1'b0;
  logic             o_VALID;
  logic             i_READY = 1'b0;
  logic [WIDTH-1:0] o_Y;
  logic             o_overflow;
  logic             o_err;
  logic [CW-1:0]    o_count;
  logic [7:0]       o_ovf_cnt;
  logic [7:0]       o_err_cnt;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_FLUSH(i_FLUSH),
    .i_VALID(i_VALID), .o_READY(o_READY), .i_Y(i_Y),
    .i_overflow(i_overflow), .i_err(i_err),
    .o_VALID(o_VALID), .i_READY(i_READY), .o_Y(o_Y),
    .o_overflow(o_overflow), .o_err(o_err), .o_count(o_count),
    .o_ovf_cnt(o_ovf_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 i_CLK = ~i_CLK;

  // Reference model: ordered queue of {err, ovf, y} plus saturating stats.
  logic [WIDTH+1:0] q[$];
  int unsigned      m_ovf;
  int unsigned      m_err;
  int unsigned      checks = 0;
  int unsigned      failures = 0;

`ifdef ALU_RESULT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic compare_all();
    logic [WIDTH+1:0] head;
    check("count", 32'(o_count), 32'(q.size()));
    check("valid", 32'(o_VALID), 32'(q.size() != 0));
    check("ready", 32'(o_READY), 32'(q.size() != DEPTH));
    if (q.size() != 0) begin
      head = q[0];
      check("head_y",   32'(o_Y),        32'(head[WIDTH-1:0]));
      check("head_ovf", 32'(o_overflow), 32'(head[WIDTH]));
      check("head_err", 32'(o_err),      32'(head[WIDTH+1]));
    end
    check("ovf_cnt", 32'(o_ovf_cnt), STATS ? m_ovf : 32'd0);
    check("err_cnt", 32'(o_err_cnt), STATS ? m_err : 32'd0);
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic step(input logic rst, input logic flush, input logic v,
                      input logic [WIDTH-1:0] y, input logic ov, input logic er,
                      input logic rd);
    bit do_push;
    bit do_pop;
    i_RST = rst; i_FLUSH = flush; i_VALID = v; i_Y = y;
    i_overflow = ov; i_err = er; i_READY = rd;
    @(posedge i_CLK);
    if (rst) begin
      q.delete(); m_ovf = 0; m_err = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_push = v && (q.size() < DEPTH);
      do_pop  = rd && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({er, ov, y});
        if (ov) m_ovf = sat_inc(m_ovf);
        if (er) m_err = sat_inc(m_err);
      end
    end
    @(negedge i_CLK);
    compare_all();
  endtask

  initial begin
    m_ovf = 0; m_err = 0;
    @(negedge i_CLK);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_ready", 32'(o_READY), 32'd1);
    check("rst_valid", 32'(o_VALID), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);

    // In-order push then drain.
    step(0, 0, 1, 4'd3, 0, 0, 0);
    check("lat1_valid", 32'(o_VALID), 32'd1);
    step(0, 0, 1, 4'd5, 0, 0, 0);
    step(0, 0, 1, 4'd7, 0, 0, 0);
    check("three_count", 32'(o_count), 32'd3);
    check("three_head", 32'(o_Y), 32'd3);
    step(0, 0, 0, 0, 0, 0, 1);
    check("drain_y1", 32'(o_Y), 32'd5);
    step(0, 0, 0, 0, 0, 0, 1);
    check("drain_y2", 32'(o_Y), 32'd7);
    step(0, 0, 0, 0, 0, 0, 1);
    check("drain_empty", 32'(o_VALID), 32'd0);

    // Fill, reject a fifth, then one pop reopens o_READY.
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 4'(i), 0, 0, 0);
    check("full_ready", 32'(o_READY), 32'd0);
    step(0, 0, 1, 4'd9, 0, 0, 0);
    check("full_count", 32'(o_count), 32'd4);
    step(0, 0, 0, 0, 0, 0, 1);
    check("reopen_ready", 32'(o_READY), 32'd1);
    check("reopen_head", 32'(o_Y), 32'd2);

    // Refill, then stream through the full buffer across pointer wrap.
    step(0, 0, 1, 4'd5, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 4'(10 + k), 0, 0, 1);
      check("stream_cnt_ge3", 32'(o_count >= 3), 32'd1);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1);

    // Stats: 3 overflow and 2 error pushes after a reset.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 4'd1, 1, 0, 1);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 4'd2, 0, 1, 1);
    check("stat_ovf3", 32'(o_ovf_cnt), STATS ? 32'd3 : 32'd0);
    check("stat_err2", 32'(o_err_cnt), STATS ? 32'd2 : 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Flush with a concurrent push: entry discarded, stats kept.
    step(0, 0, 1, 4'd6, 0, 0, 0);
    step(0, 0, 1, 4'd8, 0, 0, 0);
    step(0, 1, 1, 4'd11, 1, 1, 0);
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_valid", 32'(o_VALID), 32'd0);
    check("flush_ovf", 32'(o_ovf_cnt), STATS ? 32'd3 : 32'd0);
    check("flush_err", 32'(o_err_cnt), STATS ? 32'd2 : 32'd0);

    // Saturation of the overflow counter.
    for (int k = 0; k < 300; k++) step(0, 0, 1, 4'(k), 1, 0, 1);
    check("sat_ovf", 32'(o_ovf_cnt), STATS ? 32'd255 : 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Reset during push and pop.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 4'(k + 4), 0, 1, 0);
    step(1, 0, 1, 4'd15, 1, 1, 1);
    check("rstmid_count", 32'(o_count), 32'd0);
    check("rstmid_valid", 32'(o_VALID), 32'd0);
    check("rstmid_ready", 32'(o_READY), 32'd1);
    check("rstmid_ovf", 32'(o_ovf_cnt), 32'd0);
    check("rstmid_err", 32'(o_err_cnt), 32'd0);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
           1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0) ^ (k[8] == 1'b1 && $urandom_range(0, 1) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
